// File: rtl/rob_pkg.sv
// rob_pkg: shared payload, index and exception types for the reorder buffer (rev 1.0).
// The exception types are only consumed when REORDER_BUFFER_EXC_EN is defined.
`default_nettype none

package rob_pkg;

   localparam int ROB_DEPTH  = 16;
   localparam int ROB_AREG_W = 5;
   localparam int ROB_PREG_W = 6;
   localparam int EXC_W      = 5;

   typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx_t;

   typedef struct packed {
      logic [ROB_AREG_W-1:0] areg;
      logic [ROB_PREG_W-1:0] preg;
      logic [ROB_PREG_W-1:0] old_preg;
      logic [31:0]           pc;
      logic                  has_dst;
   } rob_entry_t;

   typedef struct packed {
      logic       valid;
      rob_entry_t entry;
   } w_req_t;

   typedef struct packed {
      rob_idx_t idx;
   } w_resp_t;

   typedef struct packed {
      logic       valid;
      rob_entry_t entry;
   } commit_t;

   typedef enum logic [EXC_W-1:0] {
      EXC_NONE       = 5'h00,
      EXC_MISALIGN   = 5'h01,
      EXC_ILLEGAL    = 5'h02,
      EXC_BREAKPOINT = 5'h03,
      EXC_LOAD_FAULT = 5'h04
   } rob_exc_e;

endpackage

`default_nettype wire

// File: rtl/rob_commit_sel.sv
// rob_commit_sel: prefix-AND over the head window giving commit lane valids and count (rev 1.0).
`default_nettype none

module rob_commit_sel #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 5
) (
   input  logic [WIDTH-1:0] done_i,
   input  logic [WIDTH-1:0] exc_i,
   input  logic [WIDTH-1:0] avail_i,
   output logic [WIDTH-1:0] valid_o,
   output logic [CNT_W-1:0] n_commit_o,
   output logic             exc_hit_o
);

   logic w_run;

   // An excepting entry retires alone on lane 0 and blocks any later lane.
   always_comb begin
      w_run      = 1'b1;
      valid_o    = '0;
      n_commit_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         valid_o[i] = w_run & avail_i[i] & done_i[i] & ((i == 0) | ~exc_i[i]);
         w_run      = valid_o[i] & ~exc_i[i];
         n_commit_o = n_commit_o + CNT_W'(valid_o[i]);
      end
   end

   assign exc_hit_o = valid_o[0] & exc_i[0];

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order-retire ROB with multi-lane allocate/commit and global flush (rev 1.0).
// Define REORDER_BUFFER_EXC_EN to add per-entry exception codes and precise self-flush.
`default_nettype none

module reorder_buffer
   import rob_pkg::*;
#(
   parameter int  WIDTH    = 2,
   parameter int  DEPTH    = ROB_DEPTH,
   parameter int  WB_PORTS = 4,
   parameter int  PREG_W   = ROB_PREG_W,
   parameter int  AREG_W   = ROB_AREG_W,
   localparam int IDX_W    = $clog2(DEPTH),
   localparam int CNT_W    = IDX_W + 1,
   localparam int ENTRY_W  = AREG_W + 2*PREG_W + 33
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [WIDTH-1:0]          alloc_valid,
   input  logic [WIDTH*ENTRY_W-1:0]  alloc_entry,
   output logic                      alloc_ready,
   output logic [WIDTH*IDX_W-1:0]    alloc_idx,
   input  logic [WB_PORTS-1:0]       wb_valid,
   input  logic [WB_PORTS*IDX_W-1:0] wb_idx,
`ifdef REORDER_BUFFER_EXC_EN
   input  logic [WB_PORTS*EXC_W-1:0] wb_exc,
   output logic [EXC_W-1:0]          commit_exc,
   output logic                      flush_o,
`endif
   output logic [WIDTH-1:0]          commit_valid,
   output logic [WIDTH*ENTRY_W-1:0]  commit_entry,
   input  logic                      flush_i,
   output logic [CNT_W-1:0]          count
);

   localparam logic [CNT_W-1:0] c_ALLOC_MAX = CNT_W'(DEPTH - WIDTH);

   logic [IDX_W:0]       head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [DEPTH-1:0]     done_q, done_d;
   logic [ENTRY_W-1:0]   payload_q [DEPTH];
`ifdef REORDER_BUFFER_EXC_EN
   logic [DEPTH-1:0][EXC_W-1:0] exc_q, exc_d;
`endif

   logic [IDX_W-1:0]     w_slot_alloc [WIDTH];
   logic [IDX_W-1:0]     w_slot_head  [WIDTH];
   logic [IDX_W-1:0]     w_wb_slot    [WB_PORTS];
   logic [IDX_W-1:0]     w_wb_ofs     [WB_PORTS];
   logic [WIDTH-1:0]     w_win_done, w_win_exc, w_win_avail;
   logic [CNT_W-1:0]     w_n_alloc, w_n_commit;
   logic                 w_exc_hit, w_flush;

   assign alloc_ready = (count_q <= c_ALLOC_MAX);
   assign count       = count_q;
   assign w_flush     = flush_i | w_exc_hit;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign w_slot_alloc[i] = tail_q[IDX_W-1:0] + IDX_W'(i);
      assign w_slot_head[i]  = head_q[IDX_W-1:0] + IDX_W'(i);
      assign alloc_idx[i*IDX_W +: IDX_W]        = w_slot_alloc[i];
      assign commit_entry[i*ENTRY_W +: ENTRY_W] = payload_q[w_slot_head[i]];
      assign w_win_done[i]  = done_q[w_slot_head[i]];
      assign w_win_avail[i] = (count_q > CNT_W'(i));
`ifdef REORDER_BUFFER_EXC_EN
      assign w_win_exc[i]   = (exc_q[w_slot_head[i]] != EXC_NONE);
`else
      assign w_win_exc[i]   = 1'b0;
`endif
   end

   for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
      assign w_wb_slot[p] = wb_idx[p*IDX_W +: IDX_W];
      assign w_wb_ofs[p]  = w_wb_slot[p] - head_q[IDX_W-1:0];
      a_wb_live: assert property (@(posedge clk) disable iff (!resetn)
         wb_valid[p] |-> ({1'b0, w_wb_ofs[p]} < count_q));
   end

   rob_commit_sel #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_commit_sel (
      .done_i     (w_win_done),
      .exc_i      (w_win_exc),
      .avail_i    (w_win_avail),
      .valid_o    (commit_valid),
      .n_commit_o (w_n_commit),
      .exc_hit_o  (w_exc_hit)
   );

`ifdef REORDER_BUFFER_EXC_EN
   assign flush_o    = w_exc_hit;
   assign commit_exc = w_exc_hit ? exc_q[w_slot_head[0]] : EXC_NONE;
`endif

   // Allocation is gated by registered occupancy only; same-cycle frees are not credited.
   always_comb begin
      w_n_alloc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_n_alloc = w_n_alloc + CNT_W'(alloc_valid[i]);
      end
      if (!alloc_ready) begin
         w_n_alloc = '0;
      end
   end

   always_comb begin
      head_d  = head_q + w_n_commit;
      tail_d  = tail_q + w_n_alloc;
      count_d = count_q + w_n_alloc - w_n_commit;
      done_d  = done_q;
`ifdef REORDER_BUFFER_EXC_EN
      exc_d   = exc_q;
`endif
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p]) begin
            done_d[w_wb_slot[p]] = 1'b1;
`ifdef REORDER_BUFFER_EXC_EN
            exc_d[w_wb_slot[p]]  = wb_exc[p*EXC_W +: EXC_W];
`endif
         end
      end
      if (alloc_ready) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (alloc_valid[i]) begin
               done_d[w_slot_alloc[i]] = 1'b0;
`ifdef REORDER_BUFFER_EXC_EN
               exc_d[w_slot_alloc[i]]  = EXC_NONE;
`endif
            end
         end
      end
      if (w_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         done_d  = '0;
`ifdef REORDER_BUFFER_EXC_EN
         exc_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         done_q  <= '0;
`ifdef REORDER_BUFFER_EXC_EN
         exc_q   <= '0;
`endif
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         done_q  <= done_d;
`ifdef REORDER_BUFFER_EXC_EN
         exc_q   <= exc_d;
`endif
      end
   end

   // Payload needs no reset: a slot is only read after its allocation wrote it.
   always_ff @(posedge clk) begin
      if (alloc_ready) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (alloc_valid[i]) begin
               payload_q[w_slot_alloc[i]] <= alloc_entry[i*ENTRY_W +: ENTRY_W];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: table vectors, directed corner sequences and random traffic vs a queue model.
`default_nettype none

module tb_reorder_buffer;
   import rob_pkg::*;

   localparam int WIDTH = 2;
   localparam int DEPTH = 16;
   localparam int WBP   = 4;
   localparam int IDX_W = 4;
   localparam int CNT_W = 5;
   localparam int EW    = $bits(rob_entry_t);

   logic                  clk = 1'b0;
   logic                  resetn = 1'b0;
   logic [WIDTH-1:0]      alloc_valid = '0;
   logic [WIDTH*EW-1:0]   alloc_entry = '0;
   logic                  alloc_ready;
   logic [WIDTH*IDX_W-1:0] alloc_idx;
   logic [WBP-1:0]        wb_valid = '0;
   logic [WBP*IDX_W-1:0]  wb_idx = '0;
   logic [WBP*5-1:0]      wb_exc = '0;
   logic [WIDTH-1:0]      commit_valid;
   logic [WIDTH*EW-1:0]   commit_entry;
   logic                  flush_i = 1'b0;
   logic [CNT_W-1:0]      count;
`ifdef REORDER_BUFFER_EXC_EN
   logic [4:0]            commit_exc;
   logic                  flush_o;
`endif

   reorder_buffer dut (
      .clk          (clk),
      .resetn       (resetn),
      .alloc_valid  (alloc_valid),
      .alloc_entry  (alloc_entry),
      .alloc_ready  (alloc_ready),
      .alloc_idx    (alloc_idx),
      .wb_valid     (wb_valid),
      .wb_idx       (wb_idx),
`ifdef REORDER_BUFFER_EXC_EN
      .wb_exc       (wb_exc),
      .commit_exc   (commit_exc),
      .flush_o      (flush_o),
`endif
      .commit_valid (commit_valid),
      .commit_entry (commit_entry),
      .flush_i      (flush_i),
      .count        (count)
   );

   always #5 clk = ~clk;

   // Reference model: the buffer is a program-ordered queue of live instructions.
   typedef struct {
      int            idx;
      logic [EW-1:0] pl;
      bit            done;
      logic [4:0]    exc;
   } m_ent_t;

   m_ent_t mq[$];
   int     m_tail;
   int     e_n;
   bit     e_xf;
   int     n_pass = 0;
   int     n_total = 0;

   typedef struct {
      logic [1:0] av;
      logic       rdy;
      logic [7:0] idx;
      logic [4:0] cnt;
   } vec_t;
   vec_t tv[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_eval();
      e_n  = 0;
      e_xf = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= mq.size() || !mq[i].done) break;
         if (mq[i].exc != 0) begin
            if (i == 0) begin
               e_n  = 1;
               e_xf = 1;
            end
            break;
         end
         e_n++;
      end
   endtask

   task automatic drive_check(input logic [1:0] av, input logic [3:0] wv, input logic [15:0] wi,
                              input logic [19:0] we, input bit fl);
      logic [63:0] r;
      logic [7:0]  exp_idx;
      alloc_valid = av;
      wb_valid    = wv;
      wb_idx      = wi;
      wb_exc      = we;
      flush_i     = fl;
      for (int i = 0; i < WIDTH; i++) begin
         r = {$urandom, $urandom};
         alloc_entry[i*EW +: EW] = r[EW-1:0];
      end
      #1;
      model_eval();
      for (int i = 0; i < WIDTH; i++) exp_idx[i*IDX_W +: IDX_W] = IDX_W'((m_tail + i) % DEPTH);
      chk("alloc_ready", alloc_ready, (DEPTH - mq.size()) >= WIDTH);
      chk("alloc_idx", alloc_idx, exp_idx);
      chk("commit_valid", commit_valid, (1 << e_n) - 1);
      for (int i = 0; i < e_n; i++) chk("commit_entry", commit_entry[i*EW +: EW], mq[i].pl);
      chk("count", count, mq.size());
`ifdef REORDER_BUFFER_EXC_EN
      chk("flush_o", flush_o, e_xf);
      chk("commit_exc", commit_exc, e_xf ? mq[0].exc : 5'h0);
`endif
   endtask

   task automatic finish_cycle();
      bit rdy;
      int na;
      rdy = (DEPTH - mq.size()) >= WIDTH;
      for (int i = 0; i < e_n; i++) void'(mq.pop_front());
      for (int p = 0; p < WBP; p++) begin
         if (wb_valid[p]) begin
            foreach (mq[k]) begin
               if (mq[k].idx == int'(wb_idx[p*IDX_W +: IDX_W])) begin
                  mq[k].done = 1;
`ifdef REORDER_BUFFER_EXC_EN
                  mq[k].exc  = wb_exc[p*5 +: 5];
`endif
               end
            end
         end
      end
      if (rdy) begin
         na = 0;
         for (int i = 0; i < WIDTH; i++) begin
            if (alloc_valid[i]) begin
               mq.push_back('{(m_tail + i) % DEPTH, alloc_entry[i*EW +: EW], 1'b0, 5'h0});
               na++;
            end
         end
         m_tail = (m_tail + na) % DEPTH;
      end
      if (flush_i || e_xf) begin
         mq.delete();
         m_tail = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn      = 1'b0;
      alloc_valid = '0;
      wb_valid    = '0;
      wb_idx      = '0;
      wb_exc      = '0;
      flush_i     = 1'b0;
      mq.delete();
      m_tail = 0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [1:0]  av;
      logic [3:0]  wv;
      logic [15:0] wi;
      logic [19:0] we;
      bit          fl;
      int          k;

      do_reset();
      #1;
      chk("rst_ready", alloc_ready, 1);
      chk("rst_commit", commit_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_idx", alloc_idx, 8'h10);

      // Back-to-back full groups: the ninth arrives with the buffer full and is dropped.
      for (int g = 0; g < 8; g++) tv[g] = '{2'b11, 1'b1, {4'(2*g + 1), 4'(2*g)}, 5'(2*g + 2)};
      tv[8] = '{2'b11, 1'b0, 8'h10, 5'd16};
      for (int g = 0; g < 9; g++) begin
         drive_check(tv[g].av, '0, '0, '0, 0);
         chk("tbl_ready", alloc_ready, tv[g].rdy);
         chk("tbl_idx", alloc_idx, tv[g].idx);
         finish_cycle();
         chk("tbl_count", count, tv[g].cnt);
      end

      // Out-of-order writebacks, in-order retirement.
      do_reset();
      drive_check(2'b11, 0, 0, 0, 0); finish_cycle();
      drive_check(2'b11, 0, 0, 0, 0); finish_cycle();
      drive_check(2'b00, 4'b0001, 16'h0001, 0, 0); finish_cycle();
      drive_check(2'b00, 4'b0001, 16'h0000, 0, 0);
      chk("ooo_wait", commit_valid, 2'b00);
      finish_cycle();
      drive_check(2'b00, 0, 0, 0, 0);
      chk("ooo_pair", commit_valid, 2'b11);
      finish_cycle();
      drive_check(2'b00, 4'b0001, 16'h0002, 0, 0);
      chk("ooo_hold", commit_valid, 2'b00);
      finish_cycle();
      drive_check(2'b00, 0, 0, 0, 0);
      chk("ooo_single", commit_valid, 2'b01);
      chk("ooo_count", count, 2);
      finish_cycle();

      // Occupancy 15: commit frees two but allocation is not credited until the next cycle.
      do_reset();
      repeat (7) begin drive_check(2'b11, 0, 0, 0, 0); finish_cycle(); end
      drive_check(2'b01, 0, 0, 0, 0); finish_cycle();
      drive_check(2'b11, 4'b0011, 16'h0010, 0, 0);
      chk("b15_ready", alloc_ready, 0);
      finish_cycle();
      drive_check(2'b11, 0, 0, 0, 0);
      chk("b15_ready_commit", alloc_ready, 0);
      chk("b15_commit", commit_valid, 2'b11);
      finish_cycle();
      drive_check(2'b00, 0, 0, 0, 0);
      chk("b15_ready_next", alloc_ready, 1);
      chk("b15_count", count, 13);
      finish_cycle();

      // Flush with a commit, an allocation and a writeback in flight.
      drive_check(2'b00, 4'b0011, 16'h0032, 0, 0); finish_cycle();
      drive_check(2'b11, 4'b0001, 16'h0004, 0, 1);
      chk("fl_commit", commit_valid, 2'b11);
      finish_cycle();
      drive_check(2'b11, 0, 0, 0, 0);
      chk("fl_count", count, 0);
      chk("fl_idx", alloc_idx, 8'h10);
      chk("fl_commit_after", commit_valid, 2'b00);
      finish_cycle();
      drive_check(2'b00, 0, 0, 0, 0);
      chk("fl_no_stale", commit_valid, 2'b00);
      finish_cycle();

`ifdef REORDER_BUFFER_EXC_EN
      do_reset();
      drive_check(2'b11, 0, 0, 0, 0); finish_cycle();
      drive_check(2'b01, 0, 0, 0, 0); finish_cycle();
      drive_check(2'b00, 4'b0111, 16'h0210, 20'h00080, 0); finish_cycle();
      drive_check(2'b00, 0, 0, 0, 0);
      chk("exc_c1_valid", commit_valid, 2'b01);
      chk("exc_c1_flush", flush_o, 0);
      finish_cycle();
      drive_check(2'b00, 0, 0, 0, 0);
      chk("exc_c2_valid", commit_valid, 2'b01);
      chk("exc_c2_flush", flush_o, 1);
      chk("exc_c2_code", commit_exc, 5'h04);
      finish_cycle();
      drive_check(2'b00, 0, 0, 0, 0);
      chk("exc_c3_valid", commit_valid, 2'b00);
      chk("exc_c3_count", count, 0);
      finish_cycle();
`endif

      // Random traffic: wraps the indices many times, fills, drains and flushes.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         av = ($urandom % 4 == 0) ? 2'b00 : (($urandom % 3 == 0) ? 2'b01 : 2'b11);
         wv = '0;
         wi = '0;
         we = '0;
         for (int p = 0; p < WBP; p++) begin
            if (mq.size() > 0 && $urandom % 3 == 0) begin
               k = int'($urandom % mq.size());
               wv[p] = 1'b1;
               wi[p*IDX_W +: IDX_W] = IDX_W'(mq[k].idx);
               if ($urandom % 24 == 0) we[p*5 +: 5] = 5'($urandom_range(31, 1));
            end
         end
         fl = ($urandom % 50 == 0);
         drive_check(av, wv, wi, we, fl);
         finish_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
